// File: rtl/i2c_host_pkg.sv
// Shared state encodings and line-level constants for the I2C host sequencer.
package i2c_host_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StLoad,
    StShift,
    StAck,
    StTransit,
    StStop,
    StStopHold
  } hostStateE;

  localparam logic SDA_RELEASE = 1'b1;

endpackage

// File: rtl/i2c_edge_pulse.sv
// Registered edge detector: one-cycle rise/fall pulses, one cycle after the input changes.
module i2c_edge_pulse #(
  parameter logic RESET_LEVEL = 1'b0
) (
  input  logic clock,
  input  logic Reset,
  input  logic sigIn,
  output logic rise,
  output logic fall
);

  logic levelQ, riseQ, fallQ;

  always_ff @(posedge clock) begin
    if (Reset) begin
      levelQ <= RESET_LEVEL;
      riseQ  <= 1'b0;
      fallQ  <= 1'b0;
    end else begin
      levelQ <= sigIn;
      riseQ  <= sigIn & ~levelQ;
      fallQ  <= ~sigIn & levelQ;
    end
  end

  assign rise = riseQ;
  assign fall = fallQ;

endmodule

// File: rtl/i2c_host_sequencer.sv
// Multi-frame I2C host sequencer: START, address frame, write/read data frames with
// per-frame ACK handling, STOP. Drives the existing shift-register/SDA-mux/baud datapath.
module i2c_host_sequencer
  import i2c_host_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned MAX_BYTES   = 4,
  parameter int unsigned CNT_W       = 3,
  parameter int unsigned HOLD_CYCLES = 250
) (
  input  logic             clock,
  input  logic             Reset,
  input  logic             Start,
  input  logic             ReadMode,
  input  logic [CNT_W-1:0] ByteCount,
  input  logic             ClockI2C,
  input  logic             SDAIn,
  output logic             WriteLoad,
  output logic             ReadorWrite,
  output logic             ShiftorHold,
  output logic             Select,
  output logic             BaudEnable,
  output logic             StartStopAck,
  output logic             Busy,
  output logic             Done,
  output logic             AckError,
  output logic [CNT_W-1:0] ByteIndex
);

  localparam int unsigned HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam int unsigned BIT_W  = $clog2(DATA_WIDTH + 1);

  hostStateE         stateQ, stateD;
  logic [HOLD_W-1:0] holdCntQ, holdCntD;
  logic [BIT_W-1:0]  bitCntQ, bitCntD;
  logic [CNT_W-1:0]  byteCountQ, byteCountD, byteIndexQ, byteIndexD;
  logic              readModeQ, readModeD, ackErrorQ, ackErrorD, doneQ, doneD;

  logic sclRise, sclFall, startRise, unusedStartFall;
  logic curRead, lastFrame, startLegal;

  // SCL idles high while the baud generator is stopped.
  i2c_edge_pulse #(.RESET_LEVEL(1'b1)) u_scl_edge (
    .clock (clock),
    .Reset (Reset),
    .sigIn (ClockI2C),
    .rise  (sclRise),
    .fall  (sclFall)
  );

  i2c_edge_pulse #(.RESET_LEVEL(1'b0)) u_start_edge (
    .clock (clock),
    .Reset (Reset),
    .sigIn (Start),
    .rise  (startRise),
    .fall  (unusedStartFall)
  );

  // The address frame (index 0) is always written.
  assign curRead    = readModeQ && (byteIndexQ != '0);
  assign lastFrame  = (byteIndexQ + CNT_W'(1)) == byteCountQ;
  assign startLegal = (ByteCount != '0) && (ByteCount <= CNT_W'(MAX_BYTES));

  always_ff @(posedge clock) begin
    if (Reset) begin
      stateQ     <= StIdle;
      holdCntQ   <= '0;
      bitCntQ    <= '0;
      byteCountQ <= '0;
      byteIndexQ <= '0;
      readModeQ  <= 1'b0;
      ackErrorQ  <= 1'b0;
      doneQ      <= 1'b0;
    end else begin
      stateQ     <= stateD;
      holdCntQ   <= holdCntD;
      bitCntQ    <= bitCntD;
      byteCountQ <= byteCountD;
      byteIndexQ <= byteIndexD;
      readModeQ  <= readModeD;
      ackErrorQ  <= ackErrorD;
      doneQ      <= doneD;
    end
  end

  always_comb begin
    stateD       = stateQ;
    holdCntD     = holdCntQ;
    bitCntD      = bitCntQ;
    byteCountD   = byteCountQ;
    byteIndexD   = byteIndexQ;
    readModeD    = readModeQ;
    ackErrorD    = ackErrorQ;
    doneD        = 1'b0;
    WriteLoad    = 1'b0;
    ReadorWrite  = 1'b0;
    ShiftorHold  = 1'b0;
    Select       = 1'b1;
    BaudEnable   = 1'b0;
    StartStopAck = SDA_RELEASE;

    case (stateQ)
      StIdle: begin
        if (startRise && startLegal) begin
          readModeD  = ReadMode;
          byteCountD = ByteCount;
          ackErrorD  = 1'b0;
          byteIndexD = '0;
          holdCntD   = '0;
          stateD     = StStart;
        end
      end
      StStart: begin
        StartStopAck = ~SDA_RELEASE;
        if (holdCntQ == HOLD_W'(HOLD_CYCLES - 1)) stateD = StLoad;
        else holdCntD = holdCntQ + HOLD_W'(1);
      end
      StLoad: begin
        WriteLoad    = 1'b1;
        BaudEnable   = 1'b1;
        StartStopAck = ~SDA_RELEASE;
        bitCntD      = '0;
        stateD       = StShift;
      end
      StShift: begin
        BaudEnable = 1'b1;
        if (curRead) begin
          ReadorWrite = 1'b1;
          if (bitCntQ == BIT_W'(DATA_WIDTH)) begin
            if (sclFall) stateD = StAck;
          end else if (sclRise) begin
            ShiftorHold = 1'b1;
            bitCntD     = bitCntQ + BIT_W'(1);
          end
        end else begin
          Select = 1'b0;
          // The first bit is already on SDA after the load, so only DATA_WIDTH-1 shifts.
          if (sclFall) begin
            if (bitCntQ == BIT_W'(DATA_WIDTH - 1)) begin
              stateD = StAck;
            end else begin
              ShiftorHold = 1'b1;
              bitCntD     = bitCntQ + BIT_W'(1);
            end
          end
        end
      end
      StAck: begin
        BaudEnable = 1'b1;
        if (curRead) StartStopAck = lastFrame ? SDA_RELEASE : ~SDA_RELEASE;
        else if (sclRise && SDAIn) ackErrorD = 1'b1;
        if (sclFall) stateD = StTransit;
      end
      StTransit: begin
        BaudEnable = 1'b1;
        byteIndexD = byteIndexQ + CNT_W'(1);
        bitCntD    = '0;
        if (ackErrorQ || lastFrame) stateD = StStop;
        else if (!readModeQ)        stateD = StLoad;
        else                        stateD = StShift;
      end
      StStop: begin
        BaudEnable   = 1'b1;
        StartStopAck = ~SDA_RELEASE;
        if (sclRise) begin
          holdCntD = '0;
          stateD   = StStopHold;
        end
      end
      StStopHold: begin
        StartStopAck = ~SDA_RELEASE;
        if (holdCntQ == HOLD_W'(HOLD_CYCLES - 1)) begin
          stateD = StIdle;
          doneD  = 1'b1;
        end else begin
          holdCntD = holdCntQ + HOLD_W'(1);
        end
      end
      default: stateD = StIdle;
    endcase
  end

  assign Busy      = (stateQ != StIdle);
  assign Done      = doneQ;
  assign AckError  = ackErrorQ;
  assign ByteIndex = byteIndexQ;

endmodule

// File: tb/tb_i2c_host_sequencer.sv
// Self-checking bench for i2c_host_sequencer: table of whole-transaction vectors plus
// hand-written sequences for Start latency, Start-while-busy and mid-transaction reset.
module tb_i2c_host_sequencer;

  localparam int HOLD = 10;

  logic       clock = 1'b0;
  logic       Reset, Start, ReadMode, SDAIn;
  logic [2:0] ByteCount;
  logic       ClockI2C = 1'b1;
  logic       WriteLoad, ReadorWrite, ShiftorHold, Select, BaudEnable, StartStopAck;
  logic       Busy, Done, AckError;
  logic [2:0] ByteIndex;

  always #5 clock = ~clock;

  i2c_host_sequencer #(
    .DATA_WIDTH  (8),
    .MAX_BYTES   (4),
    .CNT_W       (3),
    .HOLD_CYCLES (HOLD)
  ) dut (
    .clock        (clock),
    .Reset        (Reset),
    .Start        (Start),
    .ReadMode     (ReadMode),
    .ByteCount    (ByteCount),
    .ClockI2C     (ClockI2C),
    .SDAIn        (SDAIn),
    .WriteLoad    (WriteLoad),
    .ReadorWrite  (ReadorWrite),
    .ShiftorHold  (ShiftorHold),
    .Select       (Select),
    .BaudEnable   (BaudEnable),
    .StartStopAck (StartStopAck),
    .Busy         (Busy),
    .Done         (Done),
    .AckError     (AckError),
    .ByteIndex    (ByteIndex)
  );

  // Baud generator model: SCL half-period of 4 clocks, held high while disabled.
  int sclCnt = 0;
  always begin
    @(posedge clock);
    #3;
    if (!BaudEnable) begin
      ClockI2C = 1'b1;
      sclCnt   = 0;
    end else if (sclCnt == 3) begin
      ClockI2C = ~ClockI2C;
      sclCnt   = 0;
    end else begin
      sclCnt++;
    end
  end

  int checks = 0;
  int failures = 0;

  int wlCnt, shCnt, rdShCnt, doneCnt, preHold, postHold, ssaBad, frameShift, prevIdx;
  bit busySeen, seenBaud, armFall, armRise, prevScl;
  int ackLvl[8];

  always @(negedge clock) begin
    if (WriteLoad) wlCnt++;
    if (ShiftorHold) begin
      shCnt++;
      if (ReadorWrite) rdShCnt++;
    end
    if (Done) doneCnt++;
    if (Busy) busySeen = 1'b1;
    if (BaudEnable) seenBaud = 1'b1;
    if (Busy && !BaudEnable) begin
      if (!seenBaud) preHold++;
      else postHold++;
      if (StartStopAck) ssaBad++;
    end
    if (int'(ByteIndex) != prevIdx) begin
      frameShift = 0;
      prevIdx    = int'(ByteIndex);
    end
    if (ShiftorHold && ReadorWrite) begin
      frameShift++;
      if (frameShift == 8) armFall = 1'b1;
    end
    // The SCL high phase following the fall after the 8th read bit is the ACK bit.
    if (armFall && prevScl && !ClockI2C) begin
      armFall = 1'b0;
      armRise = 1'b1;
    end else if (armRise && !prevScl && ClockI2C) begin
      armRise            = 1'b0;
      ackLvl[ByteIndex]  = int'(StartStopAck);
    end
    prevScl = ClockI2C;
  end

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic clearMon();
    wlCnt = 0; shCnt = 0; rdShCnt = 0; doneCnt = 0; preHold = 0; postHold = 0; ssaBad = 0;
    busySeen = 1'b0; seenBaud = 1'b0; armFall = 1'b0; armRise = 1'b0;
    frameShift = 0; prevIdx = int'(ByteIndex);
    for (int i = 0; i < 8; i++) ackLvl[i] = -1;
  endtask

  task automatic checkResetVals(input string tag);
    chk({tag, "_WriteLoad"},    int'(WriteLoad),    0);
    chk({tag, "_ReadorWrite"},  int'(ReadorWrite),  0);
    chk({tag, "_ShiftorHold"},  int'(ShiftorHold),  0);
    chk({tag, "_Select"},       int'(Select),       1);
    chk({tag, "_BaudEnable"},   int'(BaudEnable),   0);
    chk({tag, "_StartStopAck"}, int'(StartStopAck), 1);
    chk({tag, "_Busy"},         int'(Busy),         0);
    chk({tag, "_Done"},         int'(Done),         0);
    chk({tag, "_AckError"},     int'(AckError),     0);
    chk({tag, "_ByteIndex"},    int'(ByteIndex),    0);
  endtask

  task automatic waitDone(input string tag);
    bit ok = 1'b0;
    for (int c = 0; c < 3000 && !ok; c++) begin
      tick();
      if (doneCnt > 0) ok = 1'b1;
    end
    chk({tag, "_done_within_budget"}, int'(ok), 1);
  endtask

  typedef struct {
    bit rd;
    int bc;
    bit sda;
    bit holdStart;
    int wl;
    int sh;
    int rdSh;
    int idx;
    int ae;
    int done;
    int busy;
  } vecT;

  task automatic runVec(input vecT v, input string tag);
    clearMon();
    ReadMode  = v.rd;
    ByteCount = 3'(v.bc);
    SDAIn     = v.sda;
    Start     = 1'b1;
    tick();
    tick();
    if (!v.holdStart) Start = 1'b0;
    if (v.done > 0) begin
      waitDone(tag);
      repeat (30) tick();
    end else begin
      repeat (60) tick();
    end
    Start = 1'b0;
    tick();
    chk({tag, "_writeload_pulses"}, wlCnt, v.wl);
    chk({tag, "_shift_pulses"}, shCnt, v.sh);
    chk({tag, "_read_shift_pulses"}, rdShCnt, v.rdSh);
    chk({tag, "_ByteIndex"}, int'(ByteIndex), v.idx);
    chk({tag, "_AckError"}, int'(AckError), v.ae);
    chk({tag, "_done_pulses"}, doneCnt, v.done);
    chk({tag, "_busy_seen"}, int'(busySeen), v.busy);
    chk({tag, "_busy_end"}, int'(Busy), 0);
    if (v.done > 0) begin
      chk({tag, "_start_hold_cycles"}, preHold, HOLD);
      chk({tag, "_stop_hold_cycles"}, postHold, HOLD);
      chk({tag, "_sda_released_in_hold"}, ssaBad, 0);
    end
    if (v.rd && v.done > 0) begin
      for (int f = 1; f < v.bc; f++) begin
        chk($sformatf("%s_read_ack_level_f%0d", tag, f), ackLvl[f], (f == v.bc - 1) ? 1 : 0);
      end
    end
  endtask

  vecT vecs[8];
  vecT post;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{rd:0, bc:3, sda:0, holdStart:0, wl:3, sh:21, rdSh:0,  idx:3, ae:0, done:1, busy:1};
    vecs[1] = '{rd:0, bc:3, sda:1, holdStart:0, wl:1, sh:7,  rdSh:0,  idx:1, ae:1, done:1, busy:1};
    vecs[2] = '{rd:0, bc:5, sda:0, holdStart:0, wl:0, sh:0,  rdSh:0,  idx:1, ae:1, done:0, busy:0};
    vecs[3] = '{rd:1, bc:3, sda:0, holdStart:0, wl:1, sh:23, rdSh:16, idx:3, ae:0, done:1, busy:1};
    vecs[4] = '{rd:1, bc:0, sda:0, holdStart:0, wl:0, sh:0,  rdSh:0,  idx:3, ae:0, done:0, busy:0};
    vecs[5] = '{rd:0, bc:1, sda:0, holdStart:0, wl:1, sh:7,  rdSh:0,  idx:1, ae:0, done:1, busy:1};
    vecs[6] = '{rd:1, bc:4, sda:0, holdStart:0, wl:1, sh:31, rdSh:24, idx:4, ae:0, done:1, busy:1};
    vecs[7] = '{rd:0, bc:4, sda:0, holdStart:1, wl:4, sh:28, rdSh:0,  idx:4, ae:0, done:1, busy:1};
    post    = '{rd:0, bc:2, sda:0, holdStart:0, wl:2, sh:14, rdSh:0,  idx:2, ae:0, done:1, busy:1};

    Reset = 1'b1; Start = 1'b0; ReadMode = 1'b0; ByteCount = '0; SDAIn = 1'b0;
    repeat (3) tick();
    checkResetVals("reset");
    Reset = 1'b0;
    repeat (3) tick();

    for (int i = 0; i < 8; i++) runVec(vecs[i], $sformatf("vec%0d", i));

    // Start-to-SDA-low latency, then a second Start edge while busy must be ignored.
    clearMon();
    ReadMode = 1'b0; ByteCount = 3'd2; SDAIn = 1'b0; Start = 1'b1;
    tick();
    chk("latency_1cycle_sda", int'(StartStopAck), 1);
    tick();
    chk("latency_2cycle_sda", int'(StartStopAck), 0);
    Start = 1'b0;
    for (int c = 0; c < 3000 && shCnt < 3; c++) tick();
    chk("busy_restart_reached_shift", int'(shCnt >= 3), 1);
    Start = 1'b1;
    tick();
    Start = 1'b0;
    waitDone("busy_restart");
    repeat (30) tick();
    chk("busy_restart_writeload", wlCnt, 2);
    chk("busy_restart_shifts", shCnt, 14);
    chk("busy_restart_done", doneCnt, 1);
    chk("busy_restart_index", int'(ByteIndex), 2);

    // Reset while shifting the first read data frame.
    clearMon();
    ReadMode = 1'b1; ByteCount = 3'd3; Start = 1'b1;
    tick();
    Start = 1'b0;
    for (int c = 0; c < 3000 && !ReadorWrite; c++) tick();
    chk("midreset_reached_read_shift", int'(ReadorWrite), 1);
    chk("midreset_index_before", int'(ByteIndex), 1);
    Reset = 1'b1;
    tick();
    checkResetVals("midreset");
    Reset = 1'b0;
    repeat (5) tick();
    runVec(post, "post_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/i2c_host_sequencer.md
# i2c_host_sequencer

Parametrised I2C host control sequencer; successor to the phase-1 host controller. Runs a complete multi-frame transaction: START, address frame, up to MAX_BYTES-1 data frames written or read, per-frame ACK/NACK handling, STOP. Drives the existing I2C datapath (shift register, SDA mux, baud generator) through the same control strobes, plus status outputs for the system-level FSM.

## Interface
Parameters
- DATA_WIDTH, 8: bits per frame.
- MAX_BYTES, 4: maximum frames per transaction, address frame included.
- CNT_W, 3: width of ByteCount/ByteIndex; must satisfy 2^CNT_W > MAX_BYTES.
- HOLD_CYCLES, 250: clock cycles SDA is held low for START setup and STOP setup.

Ports
- clock  in  1  system clock; single clock domain.
- Reset  in  1  synchronous, active-high reset.
- Start  in  1  rising edge requests a transaction.
- ReadMode  in  1  1 = data frames are read; 0 = written. Address frame is always written.
- ByteCount  in  CNT_W  total frames including address; legal 1..MAX_BYTES.
- ClockI2C  in  1  SCL from baud generator; generated in the clock domain; held high while BaudEnable=0.
- SDAIn  in  1  SDA line level, sampled for target ACK.
- WriteLoad  out  1  parallel-load shift register.
- ReadorWrite  out  1  shift-register direction for the current frame; 1 = read.
- ShiftorHold  out  1  one-cycle shift strobe.
- Select  out  1  SDA source: 0 = shift register, 1 = StartStopAck.
- BaudEnable  out  1  runs the baud generator.
- StartStopAck  out  1  SDA level when Select=1; 1 = released.
- Busy  out  1  high in every state except IDLE.
- Done  out  1  one-cycle pulse on return to IDLE after STOP.
- AckError  out  1  sticky; target NACKed a written frame.
- ByteIndex  out  CNT_W  frames completed in the current transaction.

## Operation
- Internal rise/fall pulses: one cycle each, asserted when ClockI2C differs from its registered copy.
- Start is also edge-detected; holding it high does not retrigger.
- Reset values: WriteLoad 0, ReadorWrite 0, ShiftorHold 0, Select 1, BaudEnable 0, StartStopAck 1, Busy 0, Done 0, AckError 0, ByteIndex 0, state IDLE.
- States:
  - IDLE: Select=1, StartStopAck=1. Start edge with ByteCount in 1..MAX_BYTES latches ReadMode and ByteCount, clears AckError and ByteIndex, then goes to START. Any other ByteCount: Start ignored.
  - START: StartStopAck=0, BaudEnable=0 for HOLD_CYCLES cycles, then LOAD.
  - LOAD: exactly one cycle. WriteLoad=1, BaudEnable=1, then SHIFT.
  - SHIFT, write frame: Select=0. Falling edges 1..DATA_WIDTH-1 each give ShiftorHold=1 in the same cycle. Falling edge DATA_WIDTH goes to ACK with no shift.
  - SHIFT, read frame: Select=1, StartStopAck=1, ReadorWrite=1. Each rising edge gives ShiftorHold=1. After DATA_WIDTH rising edges, the next falling edge goes to ACK.
  - ACK, write frame: Select=1, StartStopAck=1. SDAIn sampled on the rising edge; 1 sets AckError. Next falling edge goes to TRANSIT.
  - ACK, read frame: Select=1. StartStopAck=0 (ACK), or 1 (NACK) when this is the last frame. Next falling edge goes to TRANSIT.
  - TRANSIT: one cycle; ByteIndex+1.
    - If AckError or ByteIndex+1==ByteCount: go to STOP.
    - Else if next frame is write: go to LOAD.
    - Else (read): go to SHIFT.
  - STOP: Select=1, StartStopAck=0, BaudEnable=1. Next rising edge goes to STOPHOLD.
  - STOPHOLD: BaudEnable=0, StartStopAck=0 for HOLD_CYCLES cycles, then IDLE with Done=1 for one cycle.
- Frame 0 is always written (ReadorWrite=0). Frames 1+ follow the latched ReadMode.
- Start edge while Busy: ignored.
- Reset mid-transaction: all outputs take reset values on the next edge; SDA is released and no STOP is generated.

## Timing
- Strobes (WriteLoad, ShiftorHold, Done) are exactly one cycle wide.
- ShiftorHold is Mealy on the edge pulse and coincides with the pulse cycle. All other outputs decode the registered state.
- Start edge to StartStopAck=0: 2 cycles (edge register, then state register).
- StartStopAck is low exactly HOLD_CYCLES cycles before BaudEnable rises.
- ByteIndex updates in the cycle after TRANSIT.

## Structure
- Package i2c_host_pkg: state encodings (IDLE, START, LOAD, SHIFT, ACK, TRANSIT, STOP, STOPHOLD) and SDA_RELEASE=1.
- Sub-module i2c_edge_pulse: registered rise/fall pulse generator, instantiated for ClockI2C and for Start.
- Hold counter ($clog2(HOLD_CYCLES+1) bits) is shared by START and STOPHOLD.

## Test plan
- Write, ByteCount=3, ReadMode=0, SDAIn=0 at every ACK -> 3 WriteLoad pulses, 21 ShiftorHold pulses, ByteIndex=3, AckError=0, one Done.
- Address NACK, ByteCount=3, SDAIn=1 at first ACK -> STOP after frame 0, 1 WriteLoad, ByteIndex=1, AckError=1, Done=1.
- Read, ByteCount=3, ReadMode=1 -> 1 WriteLoad, 7+16 ShiftorHold pulses, StartStopAck=0 in ACK of frame 1 and =1 in ACK of frame 2, ReadorWrite=1 in frames 1–2.
- ByteCount=0 and ByteCount=5 with MAX_BYTES=4 -> Start ignored, Busy stays 0.
- Reset asserted during SHIFT of frame 1 -> next cycle reset values; a new Start then runs a full transaction normally.
- HOLD_CYCLES=10 -> StartStopAck low exactly 10 cycles before BaudEnable=1, and exactly 10 STOPHOLD cycles before Done.
